// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the text console writer and the VGA text renderer:
// grid geometry, blank glyph, control codes, FSM state and screen address packing.
package text_console_writer_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int COL_BITS  = 7;
  localparam int ROW_BITS  = 5;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR_ROW,
    ST_CLEAR_ALL
  } state_e;

  // Screen RAM address is {row, col}; columns beyond the visible width are simply unused.
  function automatic logic [ADDR_BITS-1:0] pack_addr(input logic [ROW_BITS-1:0] row,
                                                     input logic [COL_BITS-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream input handshake plus the screen RAM write port of the console writer.
interface text_console_writer_if;
  import text_console_writer_pkg::*;

  logic                 in_valid;
  logic [7:0]           in_char;
  logic                 in_ready;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;

  // Byte producer side (also observes the RAM write port)
  modport master (
    output in_valid, in_char,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Console writer side
  modport slave (
    input  in_valid, in_char,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/text_console_writer.sv
// Text console writer: consumes a byte stream, tracks a cursor on the character
// grid, interprets CR/LF/BS/FF and writes glyph codes into the screen RAM.
// Line advance blanks the new cursor row; FF and reset blank the whole grid.
module text_console_writer #(
  parameter int         COLS           = text_console_writer_pkg::COLS,
  parameter int         ROWS           = text_console_writer_pkg::ROWS,
  parameter logic [7:0] BLANK          = text_console_writer_pkg::BLANK,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  text_console_writer_if.slave                   bus,
  output logic [text_console_writer_pkg::COL_BITS-1:0] cursor_col,
  output logic [text_console_writer_pkg::ROW_BITS-1:0] cursor_row,
  output logic                                   busy
);
  import text_console_writer_pkg::*;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

  state_e               state_q;
  logic [COL_BITS-1:0]  col_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [COL_BITS-1:0]  clr_col_q;
  logic [ROW_BITS-1:0]  clr_row_q;
  logic                 mem_we_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [7:0]           mem_wdata_q;

  logic                 accept;
  logic [ROW_BITS-1:0]  row_adv_d;

  // Ready is withheld during reset so a held byte is never taken on the reset edge.
  assign bus.in_ready = (state_q == ST_IDLE) & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign row_adv_d    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cursor_col    = col_q;
  assign cursor_row    = row_q;
  assign busy          = (state_q != ST_IDLE);

  // Control FSM, cursor, clear sequencer and registered RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR_ALL : ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      clr_col_q   <= '0;
      clr_row_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= BLANK;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bus.in_char == CC_CR) begin
              col_q <= '0;
            end else if (bus.in_char == CC_LF) begin
              col_q     <= '0;
              row_q     <= row_adv_d;
              clr_col_q <= '0;
              state_q   <= ST_CLEAR_ROW;
            end else if (bus.in_char == CC_BS) begin
              // Backspace stops at column 0: no wrap onto the previous row.
              if (col_q != '0) begin
                col_q       <= col_q - 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= pack_addr(row_q, col_q - 1'b1);
                mem_wdata_q <= BLANK;
              end
            end else if (bus.in_char == CC_FF) begin
              col_q     <= '0;
              row_q     <= '0;
              clr_col_q <= '0;
              clr_row_q <= '0;
              state_q   <= ST_CLEAR_ALL;
            end else if (bus.in_char >= 8'h20) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= pack_addr(row_q, col_q);
              mem_wdata_q <= bus.in_char;
              if (col_q == COL_LAST) begin
                // Auto-wrap behaves like LF: the new row is blanked before more input.
                col_q     <= '0;
                row_q     <= row_adv_d;
                clr_col_q <= '0;
                state_q   <= ST_CLEAR_ROW;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
            // Remaining control codes are consumed without effect.
          end
        end

        ST_CLEAR_ROW: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= pack_addr(row_q, clr_col_q);
          mem_wdata_q <= BLANK;
          if (clr_col_q == COL_LAST) begin
            clr_col_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            clr_col_q <= clr_col_q + 1'b1;
          end
        end

        ST_CLEAR_ALL: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= pack_addr(clr_row_q, clr_col_q);
          mem_wdata_q <= BLANK;
          col_q       <= '0;
          row_q       <= '0;
          if (clr_col_q == COL_LAST) begin
            clr_col_q <= '0;
            if (clr_row_q == ROW_LAST) begin
              clr_row_q <= '0;
              state_q   <= ST_IDLE;
            end else begin
              clr_row_q <= clr_row_q + 1'b1;
            end
          end else begin
            clr_col_q <= clr_col_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
